// File: rtl/conway_engine_if.sv
// Command handshake between the UART front-end and the
// Game of Life engine.
interface conway_engine_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       done;
    logic       busy;

    modport master (
        output cmd_valid, cmd,
        input  cmd_ready, done, busy
    );

    modport slave (
        input  cmd_valid, cmd,
        output cmd_ready, done, busy
    );
endinterface

// File: rtl/conway_engine.sv
// Game of Life engine: serial neighbour count, per-cell rule decision,
// and a vsync-gated commit of the new generation into the display board.
module conway_engine #(
    parameter int LOG_WIDTH  = 3,
    parameter int LOG_HEIGHT = 3,
    parameter int GEN_BITS   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    conway_engine_if.slave                 cmd_if,
    input  logic                           wrap,
    input  logic [8:0]                     birth_mask,
    input  logic [8:0]                     survive_mask,
    input  logic                           rnd_bit,
    input  logic                           commit_en,
    input  logic                           wr_en,
    input  logic [LOG_WIDTH+LOG_HEIGHT-1:0] wr_addr,
    input  logic                           wr_data,
    input  logic [LOG_WIDTH+LOG_HEIGHT-1:0] rd_addr,
    output logic                           rd_data,
    output logic [GEN_BITS-1:0]            generation,
    output logic [LOG_WIDTH+LOG_HEIGHT:0]  population
);

    localparam int AW = LOG_WIDTH + LOG_HEIGHT;
    localparam int N  = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DECIDE, S_COMMIT,
        S_RANDOM, S_CLEAR, S_NOP
    } state_t;

    state_t            state;
    logic [N-1:0]      cur;
    logic [N-1:0]      nxt;
    logic [AW-1:0]     idx;
    logic [2:0]        nbr;
    logic [3:0]        cnt;
    logic [AW:0]       acc;

    logic [LOG_WIDTH-1:0]  cx, nx;
    logic [LOG_HEIGHT-1:0] cy, ny;
    logic dxn, dxp, dyn, dyp;
    logic oob, nbit, nxt_bit, last;

    assign cx      = idx[LOG_WIDTH-1:0];
    assign cy      = idx[AW-1:LOG_WIDTH];
    assign last    = (idx == '1);
    assign rd_data = cur[rd_addr];
    assign nxt_bit = cur[idx] ? survive_mask[cnt] : birth_mask[cnt];

    always_comb begin
        dxn = 1'b0;
        dxp = 1'b0;
        dyn = 1'b0;
        dyp = 1'b0;
        unique case (nbr)
            3'd0: begin dxn = 1'b1; dyp = 1'b1; end
            3'd1: dyp = 1'b1;
            3'd2: begin dxp = 1'b1; dyp = 1'b1; end
            3'd3: dxn = 1'b1;
            3'd4: dxp = 1'b1;
            3'd5: begin dxn = 1'b1; dyn = 1'b1; end
            3'd6: dyn = 1'b1;
            3'd7: begin dxp = 1'b1; dyn = 1'b1; end
        endcase
    end

    // Power-of-two board: plain modular add gives the toroidal neighbour.
    always_comb begin
        nx = cx;
        ny = cy;
        if (dxn) nx = cx - LOG_WIDTH'(1);
        if (dxp) nx = cx + LOG_WIDTH'(1);
        if (dyn) ny = cy - LOG_HEIGHT'(1);
        if (dyp) ny = cy + LOG_HEIGHT'(1);
        oob  = (dxn && cx == '0) || (dxp && cx == '1) ||
               (dyn && cy == '0) || (dyp && cy == '1);
        nbit = cur[{ny, nx}] & (wrap | ~oob);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_IDLE && wr_en)
                cur[wr_addr] <= wr_data;
            case (state)
                S_DECIDE: nxt[idx] <= nxt_bit;
                S_COMMIT: if (commit_en) cur[idx] <= nxt[idx];
                S_RANDOM: cur[idx] <= rnd_bit;
                S_CLEAR:  cur[idx] <= 1'b0;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            cmd_if.cmd_ready <= 1'b1;
            cmd_if.busy      <= 1'b0;
            cmd_if.done      <= 1'b0;
            generation       <= '0;
            population       <= '0;
            idx              <= '0;
            nbr              <= '0;
            cnt              <= '0;
            acc              <= '0;
        end else begin
            cmd_if.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_if.cmd_valid) begin
                        cmd_if.cmd_ready <= 1'b0;
                        cmd_if.busy      <= 1'b1;
                        idx              <= '0;
                        nbr              <= '0;
                        cnt              <= '0;
                        acc              <= '0;
                        unique case (cmd_if.cmd)
                            2'd0: state <= S_COUNT;
                            2'd1: state <= S_RANDOM;
                            2'd2: state <= S_CLEAR;
                            2'd3: state <= S_NOP;
                        endcase
                    end
                end
                S_COUNT: begin
                    cnt <= cnt + 4'(nbit);
                    nbr <= nbr + 3'd1;
                    if (nbr == 3'd7) state <= S_DECIDE;
                end
                S_DECIDE: begin
                    acc   <= acc + (AW+1)'(nxt_bit);
                    cnt   <= '0;
                    idx   <= idx + AW'(1);
                    state <= last ? S_COMMIT : S_COUNT;
                end
                S_COMMIT: begin
                    if (commit_en) begin
                        idx <= idx + AW'(1);
                        if (last) begin
                            state            <= S_IDLE;
                            cmd_if.cmd_ready <= 1'b1;
                            cmd_if.busy      <= 1'b0;
                            cmd_if.done      <= 1'b1;
                            generation       <= generation + GEN_BITS'(1);
                            population       <= acc;
                        end
                    end
                end
                S_RANDOM: begin
                    acc <= acc + (AW+1)'(rnd_bit);
                    idx <= idx + AW'(1);
                    if (last) begin
                        state            <= S_IDLE;
                        cmd_if.cmd_ready <= 1'b1;
                        cmd_if.busy      <= 1'b0;
                        cmd_if.done      <= 1'b1;
                        generation       <= '0;
                        population       <= acc + (AW+1)'(rnd_bit);
                    end
                end
                S_CLEAR: begin
                    idx <= idx + AW'(1);
                    if (last) begin
                        state            <= S_IDLE;
                        cmd_if.cmd_ready <= 1'b1;
                        cmd_if.busy      <= 1'b0;
                        cmd_if.done      <= 1'b1;
                        generation       <= '0;
                        population       <= '0;
                    end
                end
                S_NOP: begin
                    state            <= S_IDLE;
                    cmd_if.cmd_ready <= 1'b1;
                    cmd_if.busy      <= 1'b0;
                    cmd_if.done      <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conway_engine.sv
// Scoreboard bench for conway_engine: the driver queues expected
// completions, the monitor checks each done pulse and board snapshot.
module tb_conway_engine;

    localparam logic [1:0] STEP  = 2'd0;
    localparam logic [1:0] RAND  = 2'd1;
    localparam logic [1:0] CLR   = 2'd2;
    localparam logic [1:0] NOP   = 2'd3;

    localparam logic [63:0] BL_H  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BL_V  = 64'h0000_0008_0808_0000;
    localparam logic [63:0] EDGE0 = 64'h0000_0000_0000_0083;
    localparam logic [63:0] EDGEW = 64'h0100_0000_0000_0101;
    localparam logic [63:0] GLID  = 64'h0000_0000_0007_0402;
    localparam logic [63:0] HL0   = 64'h0000_001C_001C_0000;
    localparam logic [63:0] HL_HL = 64'h0000_0808_0808_0800;
    localparam logic [63:0] HL_DF = 64'h0000_0808_0008_0800;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] CORN  = 64'h8100_0000_0000_0081;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wrap, rnd_bit, commit_en;
    logic [8:0]  birth_mask, survive_mask;
    logic        wr_en, wr_data, rd_data;
    logic [5:0]  wr_addr, rd_addr;
    logic [15:0] generation;
    logic [6:0]  population;

    conway_engine_if cif();

    conway_engine #(
        .LOG_WIDTH(3), .LOG_HEIGHT(3), .GEN_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .cmd_if(cif),
        .wrap(wrap), .birth_mask(birth_mask),
        .survive_mask(survive_mask), .rnd_bit(rnd_bit),
        .commit_en(commit_en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .generation(generation), .population(population)
    );

    always #100 clk = ~clk;

    typedef struct {
        int          lat;
        logic [15:0] gen;
        logic [6:0]  pop;
        bit          chk_b;
        logic [63:0] board;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          edge_cnt = 0;
    int          accept_edge = 0;
    logic [15:0] exp_gen = '0;
    int          chk_req = 0;
    int          chk_ack = 0;
    logic [63:0] chk_board = '0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h",
                     name, got, exp);
        end
    endtask

    task automatic read_board(output logic [63:0] b);
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            #1;
            b[i] = rd_data;
        end
    endtask

    initial begin
        exp_t        e;
        logic [63:0] b;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (cif.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: got done=1 required 0");
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 64'(edge_cnt - accept_edge),
                          64'(e.lat));
                    check("generation", 64'(generation), 64'(e.gen));
                    check("population", 64'(population), 64'(e.pop));
                    check("ready_at_done", 64'(cif.cmd_ready), 64'd1);
                    if (e.chk_b) begin
                        read_board(b);
                        check("board", b, e.board);
                    end
                end
            end else if (chk_req != chk_ack) begin
                read_board(b);
                check("board_snapshot", b, chk_board);
                chk_ack = chk_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_board(input logic [63:0] b);
        for (int i = 0; i < 64; i++) begin
            wr_en   = 1'b1;
            wr_addr = 6'(i);
            wr_data = b[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input int lat,
                         input logic [6:0] p, input bit cb,
                         input logic [63:0] b);
        exp_t e;
        if (c == STEP) exp_gen = exp_gen + 16'd1;
        if (c == RAND || c == CLR) exp_gen = '0;
        e.lat   = lat;
        e.gen   = exp_gen;
        e.pop   = p;
        e.chk_b = cb;
        e.board = b;
        exp_q.push_back(e);
        cif.cmd_valid = 1'b1;
        cif.cmd       = c;
        tick();
        accept_edge   = edge_cnt;
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((exp_q.size() != 0 || cif.cmd_ready !== 1'b1)
               && k < 3000) begin
            tick();
            k++;
        end
        if (k >= 3000) begin
            tests++;
            fails++;
            $display("FAIL wait_done: got timeout required done");
            exp_q.delete();
        end
    endtask

    task automatic req_board(input logic [63:0] b);
        int k = 0;
        chk_board = b;
        chk_req++;
        while (chk_ack != chk_req && k < 10) begin
            tick();
            k++;
        end
        if (k >= 10) begin
            tests++;
            fails++;
            $display("FAIL board_req: got timeout required ack");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(cif.cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(cif.busy), 64'd0);
        check({tag, "_done"}, 64'(cif.done), 64'd0);
        check({tag, "_gen"}, 64'(generation), 64'd0);
        check({tag, "_pop"}, 64'(population), 64'd0);
    endtask

    initial begin
        #(64'd200 * 64'd80000);
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd       = NOP;
        wrap          = 1'b1;
        birth_mask    = 9'h008;
        survive_mask  = 9'h00C;
        rnd_bit       = 1'b0;
        commit_en     = 1'b1;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        issue(CLR, 64, 7'd0, 1'b1, '0);
        wait_done();
        issue(NOP, 1, 7'd0, 1'b0, '0);
        wait_done();

        write_board(BL_H);
        issue(STEP, 640, 7'd3, 1'b1, BL_V);
        wait_done();
        issue(STEP, 640, 7'd3, 1'b1, BL_H);
        wait_done();

        write_board(EDGE0);
        issue(STEP, 640, 7'd3, 1'b1, EDGEW);
        wait_done();
        write_board(EDGE0);
        wrap = 1'b0;
        issue(STEP, 640, 7'd0, 1'b1, '0);
        wait_done();
        wrap = 1'b1;

        issue(CLR, 64, 7'd0, 1'b0, '0);
        wait_done();
        write_board(GLID);
        for (int k = 1; k <= 32; k++) begin
            issue(STEP, 640, 7'd5, k == 32, GLID);
            wait_done();
        end

        write_board(HL0);
        birth_mask = 9'h048;
        issue(STEP, 640, 7'd5, 1'b1, HL_HL);
        wait_done();
        birth_mask = 9'h008;
        write_board(HL0);
        issue(STEP, 640, 7'd4, 1'b1, HL_DF);
        wait_done();

        rnd_bit = 1'b1;
        issue(RAND, 64, 7'd64, 1'b1, ONES);
        wait_done();
        rnd_bit = 1'b0;
        wrap = 1'b0;
        issue(STEP, 640, 7'd4, 1'b1, CORN);
        wait_done();
        wrap = 1'b1;

        write_board(BL_H);
        commit_en = 1'b0;
        issue(STEP, 740, 7'd3, 1'b1, BL_V);
        while (edge_cnt - accept_edge < 600) tick();
        wr_en         = 1'b1;
        wr_addr       = 6'd0;
        wr_data       = 1'b1;
        cif.cmd_valid = 1'b1;
        cif.cmd       = CLR;
        tick();
        check("stall_ready", 64'(cif.cmd_ready), 64'd0);
        check("stall_busy", 64'(cif.busy), 64'd1);
        wr_en         = 1'b0;
        cif.cmd_valid = 1'b0;
        req_board(BL_H);
        while (edge_cnt - accept_edge < 676) tick();
        commit_en = 1'b1;
        wait_done();
        repeat (70) tick();
        check("no_queued_cmd_pop", 64'(population), 64'd3);
        req_board(BL_V);

        write_board(BL_H);
        issue(STEP, 640, 7'd3, 1'b1, BL_V);
        while (edge_cnt - accept_edge < 299) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_gen = '0;
        check_reset_outputs("midreset");
        req_board(BL_H);
        issue(CLR, 64, 7'd0, 1'b1, '0);
        wait_done();

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conway_engine.md
Name: conway_engine

Overview:
- Parametrised Game of Life engine: WIDTH x HEIGHT board, 2^LOG_WIDTH x 2^LOG_HEIGHT cells.
- Runtime-selectable toroidal or dead-border edges.
- Runtime birth/survive rule masks; B3/S23 when the masks hold their default values.
- Sits between the UART command front-end and the VGA/UART renderers. Provides:
  - a command handshake;
  - a host write port;
  - a combinational display read port;
  - a commit phase gated by an external strobe (vsync), so the board never tears mid-frame.

Parameters:
- LOG_WIDTH, 3, log2 of board columns.
- LOG_HEIGHT, 3, log2 of board rows.
- GEN_BITS, 16, width of the generation counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd  in  2  0=STEP, 1=RANDOM, 2=CLEAR, 3=NOP.
- cmd_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- busy  out  1  equals ~cmd_ready.
- wrap  in  1  1=toroidal, 0=out-of-board neighbours count as dead; sampled every cycle.
- birth_mask  in  9  bit n set: a dead cell with n neighbours is born.
- survive_mask  in  9  bit n set: a live cell with n neighbours survives.
- rnd_bit  in  1  random source used by RANDOM.
- commit_en  in  1  commit phase advances only while high.
- wr_en  in  1  host cell write.
- wr_addr  in  LOG_WIDTH+LOG_HEIGHT  cell address {y,x}.
- wr_data  in  1  cell value.
- rd_addr  in  LOG_WIDTH+LOG_HEIGHT  display read address {y,x}.
- rd_data  out  1  current board cell at rd_addr, combinational.
- generation  out  GEN_BITS  completed STEP count.
- population  out  LOG_WIDTH+LOG_HEIGHT+1  live cells after the last completed command.

Behaviour:

Storage and addressing:
- Two N-cell arrays, cur and nxt, with N = 2^(LOG_WIDTH+LOG_HEIGHT).
- Cell address = y*WIDTH + x.
- rd_data always reads cur.

Reset:
- Drives the following:
  - state=IDLE
  - cmd_ready=1
  - busy=0
  - done=0
  - generation=0
  - population=0
  - cell index, neighbour index, neighbour count and population accumulator = 0
- Board arrays are not cleared.
- Reset mid-command aborts immediately; partially committed cur contents are kept.

Handshake:
- A command is accepted on an edge with cmd_valid & cmd_ready.
- cmd_valid while busy is ignored and is not queued.
- done pulses high for exactly one cycle, on the edge that returns the FSM to IDLE.
- cmd_ready is high again in that same cycle.

Host write port:
- wr_en is honoured only while state=IDLE, including the accepting cycle; it is ignored while busy.
- A write and an accepted command on the same edge: the write lands first, so a STEP sees it.
- Writes do not update population.

States:
- IDLE.
- COUNT: 8 cycles per cell.
  - Neighbour order: (-1,+1), (0,+1), (+1,+1), (-1,0), (+1,0), (-1,-1), (0,-1), (+1,-1) as (dx,dy).
  - Coordinates are taken mod WIDTH/HEIGHT when wrap=1.
  - When wrap=0, any out-of-range neighbour adds 0.
  - Count is 4 bits, range 0..8.
- DECIDE: 1 cycle per cell.
  - nxt[i] = cur[i] ? survive_mask[count] : birth_mask[count].
  - The population accumulator adds nxt[i].
  - Count clears; index increments.
  - After the last cell, go to COMMIT with index 0.
- COMMIT: each cycle with commit_en=1 copies nxt[i] to cur[i] and increments i. Cycles with commit_en=0 stall with no change.
  - After the copy of cell N-1: IDLE, done=1, generation+1 (wrapping), population=accumulator.
- RANDOM: cur[i] = rnd_bit, one cell per cycle, accumulating population.
  - After cell N-1: IDLE, done, generation=0.
- CLEAR: cur[i] = 0, one cell per cycle.
  - After cell N-1: IDLE, done, generation=0, population=0.
- NOP: done on the edge after accept.

Latency (counted in edges after the accepting edge):
- STEP with commit_en held high: done after exactly 10N edges (640 for 8x8).
- RANDOM and CLEAR: done after N edges.
- NOP: done after 1 edge.

Other rules:
- cur is unchanged throughout COUNT/DECIDE; all rule evaluation uses the old generation.
- Rule masks and wrap are sampled live. They must be stable during a STEP; this is not checked.

Test Plan:
- 8x8, wrap=1, default masks, cells (3,2),(3,3),(3,4) [row,col] written, STEP, commit_en=1 -> done at edge 640; cur = {(2,3),(3,3),(4,3)}; population=3; generation=1; second STEP restores the original.
- Row 0 cols 7,0,1 alive, STEP: wrap=1 -> col 0 rows 7,0,1 alive, population=3; wrap=0 (after re-load) -> board empty, population=0.
- Glider at top-left, wrap=1, 32 STEPs -> glider translated by (+8,+8), i.e. identical board, population=5, generation=32.
- HighLife birth_mask=0x048, survive_mask=0x00C: dead cell with 6 neighbours -> born; default masks -> stays dead.
- STEP with commit_en low for 100 cycles at COMMIT entry -> cur and rd_data unchanged while stalled; done at edge 740; cmd_valid pulses while busy are ignored, and wr_en while busy leaves cur unmodified.
- Reset asserted at edge 300 of a STEP -> next cycle cmd_ready=1, done=0, generation=0, cur unchanged; CLEAR then -> done after 64 edges, all rd_data=0, population=0.
